// File: rtl/alarm_multi.sv
// alarm_multi -- 24-hour BCD clock with N programmable alarm channels,
// snooze and auto-stop.
//
// Parameters
//   CLK_HZ     clk cycles per second (>= 2)
//   N_ALARMS   number of alarm channels (1..16)
//   SNOOZE_MIN snooze length in minutes (1..59)
//   RING_SEC   ring length in seconds before auto-stop (1..255)
//
// Ports
//   clk, rstn                 system clock (rising edge), async active-low reset
//   load_i + *_init           one-cycle pulse loading hh:mm (BCD), seconds cleared
//   alarm_we_i/idx/time/en    channel write: {hd,ho,md,mo} BCD plus enable
//   snooze_i, stop_i          user pulses acting on a ringing/snoozed alarm
//   clk_sec_o                 1 Hz square wave (high in first half of each second)
//   *_now, sec_now            current time: BCD hh:mm, binary seconds
//   ring_o, ring_idx_o        ringing flag and the channel that caused it
module alarm_multi #(
  parameter int CLK_HZ     = 100000000,
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_i,
  input  logic [3:0]  hourdec_init,
  input  logic [3:0]  hourone_init,
  input  logic [3:0]  mindec_init,
  input  logic [3:0]  minone_init,
  input  logic        alarm_we_i,
  input  logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] alarm_idx_i,
  input  logic [15:0] alarm_time_i,
  input  logic        alarm_en_i,
  input  logic        snooze_i,
  input  logic        stop_i,
  output logic        clk_sec_o,
  output logic [3:0]  hourdec_now,
  output logic [3:0]  hourone_now,
  output logic [3:0]  mindec_now,
  output logic [3:0]  minone_now,
  output logic [5:0]  sec_now,
  output logic        ring_o,
  output logic [((N_ALARMS > 1) ? $clog2(N_ALARMS) : 1)-1:0] ring_idx_o
);

  localparam int              IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
  localparam int              PW          = $clog2(CLK_HZ);
  localparam logic [PW-1:0]   PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]   PRESC_HALF  = PW'(CLK_HZ / 2);
  localparam logic [5:0]      SNOOZE_LOAD = 6'(SNOOZE_MIN);
  localparam logic [7:0]      RING_LAST   = 8'(RING_SEC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

  // Legal 24-hour BCD time {hd,ho,md,mo}: 00:00 .. 23:59.
  function automatic logic bcd_time_ok(input logic [15:0] t);
    logic [3:0] hd, ho, md, mo;
    {hd, ho, md, mo} = t;
    return (hd <= 4'd2) && (ho <= 4'd9) && (md <= 4'd5) && (mo <= 4'd9) &&
           !((hd == 4'd2) && (ho > 4'd3));
  endfunction

  // ---------------------------------------------------------------- timebase
  logic [PW-1:0] presc;
  logic          sec_tick;
  logic          min_tick;
  logic          load_ok;
  logic [15:0]   load_hhmm;
  logic [15:0]   now_hhmm;
  logic [15:0]   next_hhmm;

  assign sec_tick  = (presc == PRESC_MAX);
  assign min_tick  = sec_tick && (sec_now == 6'd59);
  assign load_hhmm = {hourdec_init, hourone_init, mindec_init, minone_init};
  assign load_ok   = load_i && bcd_time_ok(load_hhmm);
  assign now_hhmm  = {hourdec_now, hourone_now, mindec_now, minone_now};
  assign clk_sec_o = (presc < PRESC_HALF);

  // hh:mm one minute from now; also the value the alarm compare looks at.
  always_comb begin : next_minute
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    next_hhmm = now_hhmm;
    if (minone_now != 4'd9) begin
      next_hhmm[3:0] = minone_now + 4'd1;
    end else begin
      next_hhmm[3:0] = 4'd0;
      if (mindec_now != 4'd5) begin
        next_hhmm[7:4] = mindec_now + 4'd1;
      end else begin
        next_hhmm[7:4] = 4'd0;
        if ((hourdec_now == 4'd2) && (hourone_now == 4'd3)) begin
          next_hhmm[15:8] = 8'h00;
        end else if (hourone_now == 4'd9) begin
          next_hhmm[11:8]  = 4'd0;
          next_hhmm[15:12] = hourdec_now + 4'd1;
        end else begin
          next_hhmm[11:8] = hourone_now + 4'd1;
        end
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc   <= '0;
      sec_now <= 6'd0;
      {hourdec_now, hourone_now, mindec_now, minone_now} <= 16'h0000;
    end else if (load_ok) begin
      presc   <= '0;
      sec_now <= 6'd0;
      {hourdec_now, hourone_now, mindec_now, minone_now} <= load_hhmm;
    end else begin
      presc <= sec_tick ? '0 : presc + PW'(1);
      if (sec_tick) begin
        if (sec_now == 6'd59) begin
          sec_now <= 6'd0;
          {hourdec_now, hourone_now, mindec_now, minone_now} <= next_hhmm;
        end else begin
          sec_now <= sec_now + 6'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------- alarm channels
  logic [15:0]         al_time [N_ALARMS];
  logic [N_ALARMS-1:0] al_en;

  // NOTE: the channel table is small register storage and must read as
  // disabled/0000 straight out of reset, so it is reset like any register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ALARMS; i++) al_time[i] <= 16'h0000;
      al_en <= '0;
    end else if (alarm_we_i && (int'(alarm_idx_i) < N_ALARMS)) begin
      al_time[alarm_idx_i] <= alarm_time_i;
      al_en[alarm_idx_i]   <= alarm_en_i && bcd_time_ok(alarm_time_i);
    end
  end

  // Lowest enabled channel equal to the upcoming minute.
  logic             hit;
  logic [IDX_W-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (al_en[i] && (al_time[i] == next_hhmm)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------- ring FSM
  state_t     state;
  logic [7:0] ring_cnt;
  logic [5:0] snooze_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      ring_o     <= 1'b0;
      ring_idx_o <= '0;
      ring_cnt   <= 8'd0;
      snooze_cnt <= 6'd0;
    end else if (load_ok) begin
      // A new wall time cancels any ring; the loaded minute itself never
      // matches because no minute tick happens on a load cycle.
      state  <= ST_IDLE;
      ring_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (min_tick && hit) begin
            state      <= ST_RING;
            ring_o     <= 1'b1;
            ring_idx_o <= hit_idx;
            ring_cnt   <= 8'd0;
          end
        end
        ST_RING: begin
          if (stop_i) begin
            state  <= ST_IDLE;
            ring_o <= 1'b0;
          end else if (snooze_i) begin
            state      <= ST_SNOOZE;
            ring_o     <= 1'b0;
            snooze_cnt <= SNOOZE_LOAD;
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state  <= ST_IDLE;
              ring_o <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop_i) begin
            state <= ST_IDLE;
          end else if (min_tick) begin
            if (snooze_cnt <= 6'd1) begin
              state    <= ST_RING;
              ring_o   <= 1'b1;
              ring_cnt <= 8'd0;
            end else begin
              snooze_cnt <= snooze_cnt - 6'd1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          ring_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_multi.sv
// tb_alarm_multi -- self-checking bench for alarm_multi (CLK_HZ=4, N_ALARMS=4,
// SNOOZE_MIN=2, RING_SEC=3). A behavioural model tracks time as seconds of
// day plus a cycle phase, alarms as minute-of-day numbers, and the ring as
// countdowns; every cycle the DUT outputs are compared against it. Directed
// scenarios add literal expectations, then randomized traffic follows.
module tb_alarm_multi;

  localparam int CLK_HZ = 4;
  localparam int N      = 4;
  localparam int SNZ    = 2;
  localparam int RSEC   = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_i;
  logic [3:0]  hourdec_init, hourone_init, mindec_init, minone_init;
  logic        alarm_we_i;
  logic [1:0]  alarm_idx_i;
  logic [15:0] alarm_time_i;
  logic        alarm_en_i;
  logic        snooze_i, stop_i;
  logic        clk_sec_o;
  logic [3:0]  hourdec_now, hourone_now, mindec_now, minone_now;
  logic [5:0]  sec_now;
  logic        ring_o;
  logic [1:0]  ring_idx_o;

  alarm_multi #(.CLK_HZ(CLK_HZ), .N_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_SEC(RSEC)) dut (
    .clk(clk), .rstn(rstn), .load_i(load_i),
    .hourdec_init(hourdec_init), .hourone_init(hourone_init),
    .mindec_init(mindec_init), .minone_init(minone_init),
    .alarm_we_i(alarm_we_i), .alarm_idx_i(alarm_idx_i),
    .alarm_time_i(alarm_time_i), .alarm_en_i(alarm_en_i),
    .snooze_i(snooze_i), .stop_i(stop_i), .clk_sec_o(clk_sec_o),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .sec_now(sec_now), .ring_o(ring_o), .ring_idx_o(ring_idx_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  typedef enum int {M_IDLE, M_RING, M_SNOOZE} mode_t;

  int    m_tod;                 // seconds since midnight
  int    m_phase;               // cycle within the current second
  mode_t m_mode;
  int    m_idx;
  int    m_ring_left;           // second ticks left before auto-stop
  int    m_snz_left;            // minute ticks left before re-ring
  int    m_al_min [N];          // alarm minute of day, -1 when invalid
  bit    m_al_en  [N];
  bit    m_tick, m_mtick;
  int    m_next_tod, m_match;

  function automatic bit time_ok(input int hd, input int ho, input int md, input int mo);
    return (hd <= 9) && (ho <= 9) && (md <= 5) && (mo <= 9) && (hd * 10 + ho <= 23);
  endfunction

  function automatic logic [15:0] to_bcd(input int min_of_day);
    int h, m;
    h = min_of_day / 60;
    m = min_of_day % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tod = 0; m_phase = 0; m_mode = M_IDLE; m_idx = 0;
      m_ring_left = 0; m_snz_left = 0;
      for (int i = 0; i < N; i++) begin m_al_min[i] = -1; m_al_en[i] = 1'b0; end
    end else begin
      m_tick     = (m_phase == CLK_HZ - 1);
      m_mtick    = m_tick && (m_tod % 60 == 59);
      m_next_tod = (m_tod + 1) % 86400;
      if (load_i && time_ok(hourdec_init, hourone_init, mindec_init, minone_init)) begin
        m_tod   = ((hourdec_init * 10 + hourone_init) * 60 + mindec_init * 10 + minone_init) * 60;
        m_phase = 0;
        m_mode  = M_IDLE;
      end else begin
        m_match = -1;
        if (m_mtick)
          for (int i = N - 1; i >= 0; i--)
            if (m_al_en[i] && m_al_min[i] == m_next_tod / 60) m_match = i;
        case (m_mode)
          M_IDLE:
            if (m_match >= 0) begin m_mode = M_RING; m_idx = m_match; m_ring_left = RSEC; end
          M_RING:
            if (stop_i) m_mode = M_IDLE;
            else if (snooze_i) begin m_mode = M_SNOOZE; m_snz_left = SNZ; end
            else if (m_tick) begin
              m_ring_left--;
              if (m_ring_left == 0) m_mode = M_IDLE;
            end
          default:
            if (stop_i) m_mode = M_IDLE;
            else if (m_mtick) begin
              m_snz_left--;
              if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RSEC; end
            end
        endcase
        m_phase = (m_phase + 1) % CLK_HZ;
        if (m_tick) m_tod = m_next_tod;
      end
      if (alarm_we_i && alarm_idx_i < N) begin
        if (time_ok(alarm_time_i[15:12], alarm_time_i[11:8], alarm_time_i[7:4], alarm_time_i[3:0])) begin
          m_al_min[alarm_idx_i] = (alarm_time_i[15:12] * 10 + alarm_time_i[11:8]) * 60 +
                                  alarm_time_i[7:4] * 10 + alarm_time_i[3:0];
          m_al_en[alarm_idx_i]  = alarm_en_i;
        end else begin
          m_al_min[alarm_idx_i] = -1;
          m_al_en[alarm_idx_i]  = 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------ compare process
  bit model_on = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      check("clk_sec", clk_sec_o, m_phase < CLK_HZ / 2);
      check("hhmm", {hourdec_now, hourone_now, mindec_now, minone_now}, to_bcd(m_tod / 60));
      check("sec", sec_now, m_tod % 60);
      check("ring", ring_o, m_mode == M_RING);
      if (m_mode == M_RING) check("ring_idx", ring_idx_o, m_idx);
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] t);
    {hourdec_init, hourone_init, mindec_init, minone_init} = t;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic write_alarm(input int idx, input logic [15:0] t, input bit en);
    alarm_we_i = 1'b1; alarm_idx_i = 2'(idx); alarm_time_i = t; alarm_en_i = en;
    @(negedge clk);
    alarm_we_i = 1'b0;
  endtask

  task automatic pulse(input bit snz, input bit stp);
    snooze_i = snz; stop_i = stp;
    @(negedge clk);
    snooze_i = 1'b0; stop_i = 1'b0;
  endtask

  function automatic logic [15:0] hhmm_now();
    return {hourdec_now, hourone_now, mindec_now, minone_now};
  endfunction

  // ------------------------------------------------------------ main sequence
  initial begin
    rstn = 1'b0; load_i = 1'b0; alarm_we_i = 1'b0; alarm_idx_i = 2'd0;
    alarm_time_i = 16'h0; alarm_en_i = 1'b0; snooze_i = 1'b0; stop_i = 1'b0;
    {hourdec_init, hourone_init, mindec_init, minone_init} = 16'h0;
    cyc(2);
    check("reset_hhmm", hhmm_now(), 16'h0000);
    check("reset_sec", sec_now, 0);
    check("reset_ring", ring_o, 0);
    check("reset_idx", ring_idx_o, 0);
    check("reset_clk_sec", clk_sec_o, 1);
    model_on = 1'b1;
    #2 rstn = 1'b1;
    cyc(3);

    // Rollover and 1 Hz waveform
    do_load(16'h2359);
    check("load_hhmm", hhmm_now(), 16'h2359);
    check("load_sec", sec_now, 0);
    check("clk_sec_ph0", clk_sec_o, 1);
    cyc(1); check("clk_sec_ph1", clk_sec_o, 1);
    cyc(1); check("clk_sec_ph2", clk_sec_o, 0);
    cyc(1); check("clk_sec_ph3", clk_sec_o, 0);
    cyc(1); check("sec_after_4", sec_now, 1);
    cyc(236);
    check("rollover_hhmm", hhmm_now(), 16'h0000);
    check("rollover_sec", sec_now, 0);

    // Priority: ch0 disabled, ch1 and ch3 enabled at 07:00
    write_alarm(0, 16'h0700, 1'b0);
    write_alarm(1, 16'h0700, 1'b1);
    write_alarm(3, 16'h0700, 1'b1);
    do_load(16'h0659);
    cyc(239);
    check("pre_ring", ring_o, 0);
    cyc(1);
    check("prio_ring", ring_o, 1);
    check("prio_idx", ring_idx_o, 1);

    // Auto-stop after three second ticks
    cyc(11); check("ring_before_timeout", ring_o, 1);
    cyc(1);  check("ring_timeout", ring_o, 0);

    // Second ring, stop and snooze together: stop wins
    do_load(16'h0659);
    cyc(240);
    check("ring2", ring_o, 1);
    pulse(1'b1, 1'b1);
    check("stop_wins", ring_o, 0);
    cyc(500);
    check("no_rering_after_stop", ring_o, 0);

    // Snooze: re-rings two minute ticks later with the same channel
    do_load(16'h0659);
    cyc(240);
    check("ring3", ring_o, 1);
    pulse(1'b1, 1'b0);
    check("snoozed", ring_o, 0);
    cyc(478); check("snooze_wait", ring_o, 0);
    cyc(1);   check("snooze_rering", ring_o, 1);
    check("snooze_idx", ring_idx_o, 1);
    pulse(1'b0, 1'b1);
    check("stop_after_snooze", ring_o, 0);

    // Invalid loads are ignored; a disabled matching channel does not ring
    do_load(16'h1234);
    do_load(16'h2400);
    check("load_24_ignored", hhmm_now(), 16'h1234);
    do_load(16'h1260);
    check("load_min60_ignored", hhmm_now(), 16'h1234);
    write_alarm(2, 16'h1300, 1'b0);
    do_load(16'h1259);
    cyc(240);
    check("disabled_hhmm", hhmm_now(), 16'h1300);
    check("disabled_no_ring", ring_o, 0);

    // Reset while snoozing
    do_load(16'h0659);
    cyc(240);
    check("ring4", ring_o, 1);
    pulse(1'b1, 1'b0);
    cyc(50);
    #2 rstn = 1'b0;
    cyc(2);
    check("rst_ring", ring_o, 0);
    check("rst_hhmm", hhmm_now(), 16'h0000);
    check("rst_sec", sec_now, 0);
    #2 rstn = 1'b1;
    cyc(720);
    check("post_rst_hhmm", hhmm_now(), 16'h0003);
    check("post_rst_sec", sec_now, 0);
    check("post_rst_no_ring", ring_o, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 8000; c++) begin
      snooze_i   = ($urandom_range(0, 59) == 0);
      stop_i     = ($urandom_range(0, 119) == 0);
      load_i     = ($urandom_range(0, 699) == 0);
      alarm_we_i = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0)
        {hourdec_init, hourone_init, mindec_init, minone_init} = to_bcd($urandom_range(0, 1439));
      else
        {hourdec_init, hourone_init, mindec_init, minone_init} = 16'($urandom);
      alarm_idx_i = 2'($urandom_range(0, 3));
      alarm_en_i  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0)
        alarm_time_i = to_bcd((m_tod / 60 + $urandom_range(1, 3)) % 1440);
      else
        alarm_time_i = 16'($urandom);
      @(negedge clk);
      if (c == 4000) begin
        load_i = 1'b0; alarm_we_i = 1'b0; snooze_i = 1'b0; stop_i = 1'b0;
        #2 rstn = 1'b0;
        cyc(2);
        #2 rstn = 1'b1;
      end
    end
    load_i = 1'b0; alarm_we_i = 1'b0; snooze_i = 1'b0; stop_i = 1'b0;
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
